// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM slot arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_VID  = 2'd1,
      GNT_CPU  = 2'd2,
      GNT_LDR  = 2'd3
   } grant_e;

   localparam int PORT_VID = 0;
   localparam int PORT_CPU = 1;
   localparam int PORT_LDR = 2;

   localparam int VID_MAX_RUN_DEF = 3;
   localparam int RUN_W           = 3;

   // Round-robin pointer: which of CPU/loader is preferred on the next tie.
   localparam logic RR_CPU = 1'b0;
   localparam logic RR_LDR = 1'b1;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and controller signals of the SDRAM arbiter; the arbiter uses the
// slave modport, the requester/controller side uses master.
interface sdram_arbiter_if #(parameter int ADDR_W = 24);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic [63:0]       vid_data;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [1:0]        cpu_ds;
   logic [15:0]       cpu_din;
   logic              cpu_ack;
   logic [15:0]       cpu_dout;
   logic              ldr_req;
   logic [ADDR_W-1:0] ldr_addr;
   logic [15:0]       ldr_din;
   logic              ldr_ack;
   logic              sd_req;
   logic              sd_we;
   logic [ADDR_W-1:0] sd_addr;
   logic [1:0]        sd_ds;
   logic [15:0]       sd_din;
   logic [15:0]       sd_dout;
   logic [63:0]       sd_dout64;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
             ldr_req, ldr_addr, ldr_din, sd_dout, sd_dout64,
      output vid_ack, vid_data, cpu_ack, cpu_dout, ldr_ack,
             sd_req, sd_we, sd_addr, sd_ds, sd_din
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
             ldr_req, ldr_addr, ldr_din, sd_dout, sd_dout64,
      input  vid_ack, vid_data, cpu_ack, cpu_dout, ldr_ack,
             sd_req, sd_we, sd_addr, sd_ds, sd_din
   );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: video priority with a bounded run while the
// CPU waits, CPU/loader alternating by round-robin pointer.
module sdram_arb_pick
   import sdram_arb_pkg::*;
#(
   parameter int VID_MAX_RUN = VID_MAX_RUN_DEF
) (
   input  logic             vid_el_i,
   input  logic             cpu_el_i,
   input  logic             ldr_el_i,
   input  logic [RUN_W-1:0] vid_run_i,
   input  logic             rr_i,
   output grant_e           win_o
);

   always_comb begin
      win_o = GNT_IDLE;
      if (vid_el_i) begin
         if (cpu_el_i && vid_run_i == RUN_W'(VID_MAX_RUN)) win_o = GNT_CPU;
         else                                               win_o = GNT_VID;
      end else if (cpu_el_i && ldr_el_i) begin
         win_o = (rr_i == RR_LDR) ? GNT_LDR : GNT_CPU;
      end else if (cpu_el_i) begin
         win_o = GNT_CPU;
      end else if (ldr_el_i) begin
         win_o = GNT_LDR;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot arbiter sharing one SDRAM controller port between video, CPU and loader.
// Every clk_8_en edge completes the previous slot and issues the next one.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int VID_MAX_RUN = VID_MAX_RUN_DEF,
   parameter int ADDR_W      = 24
) (
   input  logic           clk_96,
   input  logic           reset_n,
   input  logic           clk_8_en,
   sdram_arbiter_if.slave bus
);

   grant_e              grant_q, grant_d, win;
   logic [RUN_W-1:0]    run_q, run_d;
   logic                rr_q, rr_d;
   logic                sd_req_q, sd_req_d, sd_we_q, sd_we_d;
   logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
   logic [1:0]          sd_ds_q, sd_ds_d;
   logic [15:0]         sd_din_q, sd_din_d;
   logic                vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, ldr_ack_q, ldr_ack_d;
   logic [63:0]         vid_data_q, vid_data_d;
   logic [15:0]         cpu_dout_q, cpu_dout_d;
   logic                vid_el, cpu_el, ldr_el;

   // Video is a streaming prefetcher and may hold consecutive slots (bounded by
   // VID_MAX_RUN); CPU and loader still show req on their ack edge, so mask them.
   assign vid_el = bus.vid_req;
   assign cpu_el = bus.cpu_req && (grant_q != GNT_CPU);
   assign ldr_el = bus.ldr_req && (grant_q != GNT_LDR);

   sdram_arb_pick #(.VID_MAX_RUN(VID_MAX_RUN)) u_pick (
      .vid_el_i  (vid_el),
      .cpu_el_i  (cpu_el),
      .ldr_el_i  (ldr_el),
      .vid_run_i (run_q),
      .rr_i      (rr_q),
      .win_o     (win)
   );

   always_comb begin
      grant_d    = grant_q;
      run_d      = run_q;
      rr_d       = rr_q;
      sd_req_d   = sd_req_q;
      sd_we_d    = sd_we_q;
      sd_addr_d  = sd_addr_q;
      sd_ds_d    = sd_ds_q;
      sd_din_d   = sd_din_q;
      vid_data_d = vid_data_q;
      cpu_dout_d = cpu_dout_q;
      vid_ack_d  = 1'b0;
      cpu_ack_d  = 1'b0;
      ldr_ack_d  = 1'b0;
      if (clk_8_en) begin
         unique case (grant_q)
            GNT_VID: begin
               vid_data_d = bus.sd_dout64;
               vid_ack_d  = 1'b1;
            end
            GNT_CPU: begin
               if (!sd_we_q) cpu_dout_d = bus.sd_dout;
               cpu_ack_d = 1'b1;
            end
            GNT_LDR:  ldr_ack_d = 1'b1;
            default: ;
         endcase

         grant_d = win;
         if (!bus.cpu_req) run_d = '0;
         unique case (win)
            GNT_VID: begin
               sd_req_d  = 1'b1;
               sd_we_d   = 1'b0;
               sd_addr_d = bus.vid_addr;
               sd_ds_d   = 2'b11;
               if (bus.cpu_req && run_q < RUN_W'(VID_MAX_RUN)) run_d = run_q + 1'b1;
            end
            GNT_CPU: begin
               sd_req_d  = 1'b1;
               sd_we_d   = bus.cpu_we;
               sd_addr_d = bus.cpu_addr;
               sd_ds_d   = bus.cpu_ds;
               sd_din_d  = bus.cpu_din;
               run_d     = '0;
               rr_d      = RR_LDR;
            end
            GNT_LDR: begin
               sd_req_d  = 1'b1;
               sd_we_d   = 1'b1;
               sd_addr_d = bus.ldr_addr;
               sd_ds_d   = 2'b11;
               sd_din_d  = bus.ldr_din;
               rr_d      = RR_CPU;
            end
            default: sd_req_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_96 or negedge reset_n) begin
      if (!reset_n) begin
         grant_q    <= GNT_IDLE;
         run_q      <= '0;
         rr_q       <= RR_CPU;
         sd_req_q   <= 1'b0;
         sd_we_q    <= 1'b0;
         sd_addr_q  <= '0;
         sd_ds_q    <= 2'b11;
         sd_din_q   <= '0;
         vid_ack_q  <= 1'b0;
         cpu_ack_q  <= 1'b0;
         ldr_ack_q  <= 1'b0;
         vid_data_q <= '0;
         cpu_dout_q <= '0;
      end else begin
         grant_q    <= grant_d;
         run_q      <= run_d;
         rr_q       <= rr_d;
         sd_req_q   <= sd_req_d;
         sd_we_q    <= sd_we_d;
         sd_addr_q  <= sd_addr_d;
         sd_ds_q    <= sd_ds_d;
         sd_din_q   <= sd_din_d;
         vid_ack_q  <= vid_ack_d;
         cpu_ack_q  <= cpu_ack_d;
         ldr_ack_q  <= ldr_ack_d;
         vid_data_q <= vid_data_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

   assign bus.sd_req   = sd_req_q;
   assign bus.sd_we    = sd_we_q;
   assign bus.sd_addr  = sd_addr_q;
   assign bus.sd_ds    = sd_ds_q;
   assign bus.sd_din   = sd_din_q;
   assign bus.vid_ack  = vid_ack_q;
   assign bus.vid_data = vid_data_q;
   assign bus.cpu_ack  = cpu_ack_q;
   assign bus.cpu_dout = cpu_dout_q;
   assign bus.ldr_ack  = ldr_ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot timing, priority/run limit, CPU/loader
// alternation, write path, idle slots and mid-slot reset.
module tb_sdram_arbiter;

   localparam logic [23:0] A_VID  = 24'h100000;
   localparam logic [23:0] A_VID2 = 24'h100040;
   localparam logic [23:0] A_CPU  = 24'h000123;
   localparam logic [23:0] A_CPUW = 24'h000456;
   localparam logic [23:0] A_LDR  = 24'h200000;

   logic clk_96  = 1'b0;
   logic reset_n = 1'b0;
   logic clk_8_en = 1'b0;
   int   en_cnt  = 0;
   int   npass   = 0;
   int   ntotal  = 0;

   sdram_arbiter_if #(.ADDR_W(24)) bus ();

   sdram_arbiter #(.VID_MAX_RUN(3), .ADDR_W(24)) dut (
      .clk_96   (clk_96),
      .reset_n  (reset_n),
      .clk_8_en (clk_8_en),
      .bus      (bus)
   );

   always #5 clk_96 = ~clk_96;

   // Strobe changes on the falling edge so it is stable at every rising edge.
   always @(negedge clk_96) begin
      en_cnt   = (en_cnt == 11) ? 0 : en_cnt + 1;
      clk_8_en = (en_cnt == 0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic slot();
      do @(posedge clk_96); while (!clk_8_en);
      #1;
   endtask

   function automatic logic [63:0] acks();
      return 64'({bus.vid_ack, bus.cpu_ack, bus.ldr_ack});
   endfunction

   // One slot edge: check the completing ack and the newly issued access.
   task automatic step(input string tag, input logic [2:0] ack, input logic req,
                       input logic [23:0] addr, input logic we, input logic [1:0] ds);
      slot();
      chk({tag, ".ack"}, acks(), 64'(ack));
      chk({tag, ".req"}, 64'(bus.sd_req), 64'(req));
      if (req) begin
         chk({tag, ".addr"}, 64'(bus.sd_addr), 64'(addr));
         chk({tag, ".we"},   64'(bus.sd_we),   64'(we));
         chk({tag, ".ds"},   64'(bus.sd_ds),   64'(ds));
      end
   endtask

   initial begin
      int n;
      bus.vid_req = 0; bus.vid_addr = A_VID;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = A_CPU; bus.cpu_ds = 2'b11; bus.cpu_din = 0;
      bus.ldr_req = 0; bus.ldr_addr = A_LDR; bus.ldr_din = 16'h5A5A;
      bus.sd_dout = 16'hBEEF; bus.sd_dout64 = 64'h0123_4567_89AB_CDEF;

      // Reset spans several strobes, which must be ignored.
      repeat (30) @(posedge clk_96);
      #1;
      chk("rst.req",  64'(bus.sd_req),  64'd0);
      chk("rst.we",   64'(bus.sd_we),   64'd0);
      chk("rst.addr", 64'(bus.sd_addr), 64'd0);
      chk("rst.ds",   64'(bus.sd_ds),   64'd3);
      chk("rst.din",  64'(bus.sd_din),  64'd0);
      chk("rst.ack",  acks(),           64'd0);
      chk("rst.vdat", bus.vid_data,     64'd0);
      chk("rst.cdat", 64'(bus.cpu_dout), 64'd0);
      @(negedge clk_96);
      reset_n = 1;

      // Three idle slots.
      for (int i = 0; i < 3; i++) step("idle", 3'b000, 1'b0, '0, 1'b0, 2'b11);

      // CPU read rising one cycle after a slot edge: issue 11 cycles later.
      @(posedge clk_96); #1;
      bus.cpu_req = 1;
      n = 0;
      do begin @(posedge clk_96); #1; n++; end while (!bus.sd_req && n < 40);
      chk("rd.issue_lat", 64'(n), 64'd11);
      chk("rd.we",   64'(bus.sd_we),   64'd0);
      chk("rd.addr", 64'(bus.sd_addr), 64'(A_CPU));
      n = 0;
      do begin @(posedge clk_96); #1; n++; end while (!bus.cpu_ack && n < 40);
      chk("rd.ack_lat", 64'(n), 64'd12);
      chk("rd.dout",    64'(bus.cpu_dout), 64'h0000_0000_0000_BEEF);
      chk("rd.req_excl", 64'(bus.sd_req), 64'd0);
      @(posedge clk_96); #1;
      chk("rd.ack_pulse", acks(), 64'd0);

      // CPU write: strobes/data pass through, later input changes have no effect.
      bus.cpu_we = 1; bus.cpu_addr = A_CPUW; bus.cpu_ds = 2'b01; bus.cpu_din = 16'h00A5;
      bus.sd_dout = 16'h1111;
      step("wr", 3'b000, 1'b1, A_CPUW, 1'b1, 2'b01);
      chk("wr.din", 64'(bus.sd_din), 64'h00A5);
      bus.cpu_din = 16'hFFFF; bus.cpu_ds = 2'b10;
      repeat (5) @(posedge clk_96);
      #1;
      chk("wr.din_held", 64'(bus.sd_din), 64'h00A5);
      chk("wr.ds_held",  64'(bus.sd_ds),  64'd1);
      slot();
      chk("wr.ack",  acks(), 64'b010);
      chk("wr.dout", 64'(bus.cpu_dout), 64'h0000_0000_0000_BEEF);
      bus.cpu_req = 0;

      // CPU and loader together; last CPU/LDR grant was CPU so loader goes first.
      bus.cpu_we = 0; bus.cpu_addr = A_CPU; bus.cpu_ds = 2'b10;
      bus.cpu_req = 1; bus.ldr_req = 1;
      step("rr1", 3'b000, 1'b1, A_LDR, 1'b1, 2'b11);
      chk("rr1.din", 64'(bus.sd_din), 64'h5A5A);
      step("rr2", 3'b001, 1'b1, A_CPU, 1'b0, 2'b10);
      step("rr3", 3'b010, 1'b1, A_LDR, 1'b1, 2'b11);
      step("rr4", 3'b001, 1'b1, A_CPU, 1'b0, 2'b10);
      bus.ldr_req = 0;
      step("rr5", 3'b010, 1'b0, '0, 1'b0, 2'b11);
      chk("rr5.dout", 64'(bus.cpu_dout), 64'h1111);

      // Video and CPU together, run limit 3: V V V C V V V C.
      bus.vid_req = 1; bus.vid_addr = A_VID;
      step("vc1", 3'b000, 1'b1, A_VID, 1'b0, 2'b11);
      step("vc2", 3'b100, 1'b1, A_VID, 1'b0, 2'b11);
      chk("vc2.vdat", bus.vid_data, 64'h0123_4567_89AB_CDEF);
      step("vc3", 3'b100, 1'b1, A_VID, 1'b0, 2'b11);
      step("vc4", 3'b100, 1'b1, A_CPU, 1'b0, 2'b10);
      bus.sd_dout = 16'h2222;
      step("vc5", 3'b010, 1'b1, A_VID, 1'b0, 2'b11);
      chk("vc5.dout", 64'(bus.cpu_dout), 64'h2222);
      step("vc6", 3'b100, 1'b1, A_VID, 1'b0, 2'b11);
      step("vc7", 3'b100, 1'b1, A_VID, 1'b0, 2'b11);
      step("vc8", 3'b100, 1'b1, A_CPU, 1'b0, 2'b10);
      bus.vid_req = 0;
      step("vc9", 3'b010, 1'b0, '0, 1'b0, 2'b11);

      // Reset five cycles into a video slot: abandoned, no ack, re-granted after.
      bus.cpu_req = 0;
      bus.vid_req = 1; bus.vid_addr = A_VID2; bus.sd_dout64 = 64'hDEAD_BEEF_CAFE_F00D;
      step("mr.issue", 3'b000, 1'b1, A_VID2, 1'b0, 2'b11);
      repeat (4) @(posedge clk_96);
      #2;
      reset_n = 0;
      #1;
      chk("mr.req",  64'(bus.sd_req),   64'd0);
      chk("mr.addr", 64'(bus.sd_addr),  64'd0);
      chk("mr.ds",   64'(bus.sd_ds),    64'd3);
      chk("mr.vdat", bus.vid_data,      64'd0);
      chk("mr.cdat", 64'(bus.cpu_dout), 64'd0);
      repeat (3) @(posedge clk_96);
      @(negedge clk_96);
      reset_n = 1;
      step("mr.regrant", 3'b000, 1'b1, A_VID2, 1'b0, 2'b11);
      bus.vid_req = 0;
      step("mr.ack", 3'b100, 1'b0, '0, 1'b0, 2'b11);
      chk("mr.vdat2", bus.vid_data, 64'hDEAD_BEEF_CAFE_F00D);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single SDRAM controller port (8 MHz slot, 96 MHz clock) between three requesters: video fetch (read-only, 64-bit burst), CPU (read/write, 16-bit), and loader (write-only, 16-bit). Each clk_8_en slot the block grants at most one requester and drives the controller's req/we/addr/ds/din for the whole slot. At the next slot boundary it returns read data and an ack pulse to the granted requester. It sits between the CPU/video/loader logic and the SDRAM controller.

Parameters:
VID_MAX_RUN, 3, max consecutive video grants while CPU is pending before CPU is forced a slot (1..7)
ADDR_W, 24, word address width

Ports:
clk_96  in  1  96 MHz system clock
reset_n  in  1  asynchronous active-low reset
clk_8_en  in  1  slot strobe, one clk_96 cycle high every 12 cycles
vid_req  in  1  video read request, level, held until vid_ack
vid_addr  in  ADDR_W  video word address (burst base)
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  64  4-word burst data
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  CPU write
cpu_addr  in  ADDR_W  CPU word address
cpu_ds  in  2  CPU byte strobes {upper, lower}
cpu_din  in  16  CPU write data
cpu_ack  out  1  one-cycle pulse, cpu_dout valid on reads
cpu_dout  out  16  CPU read data
ldr_req  in  1  loader write request, level, held until ldr_ack
ldr_addr  in  ADDR_W  loader word address
ldr_din  in  16  loader write data
ldr_ack  out  1  one-cycle pulse
sd_req  out  1  to controller req
sd_we  out  1  to controller we
sd_addr  out  ADDR_W  to controller addr
sd_ds  out  2  to controller ds
sd_din  out  16  to controller din
sd_dout  in  16  from controller dout
sd_dout64  in  64  from controller dout64

Behaviour:
- Reset (async, reset_n low): sd_req=0, sd_we=0, sd_addr=0, sd_ds=2'b11, sd_din=0, all acks 0, vid_data=0, cpu_dout=0, grant=IDLE, video run counter=0, rr pointer=CPU.
- Grant register states: IDLE, VID, CPU, LDR. All state changes happen only on clk_96 edges where clk_8_en=1 (slot edge); outputs are otherwise held constant.
- At each slot edge, in the same cycle:
  1. Completion: if grant=VID: vid_data<=sd_dout64, vid_ack pulses. If CPU: cpu_dout<=sd_dout when the access was a read (unchanged on write), cpu_ack pulses. If LDR: ldr_ack pulses. IDLE: nothing.
  2. Arbitration over requests sampled this cycle; the port just completed is excluded (its req is still high).
     - Video wins over the others unless cpu_req is eligible and vid_run==VID_MAX_RUN, in which case CPU wins.
     - With no video winner: CPU and LDR alternate by rr pointer; rr toggles to the other port after each CPU/LDR grant. A lone eligible requester always wins.
     - vid_run: +1 on each video grant while cpu_req is high, saturating at VID_MAX_RUN; cleared on a CPU grant or when cpu_req is low.
  3. Issue: the winner drives sd_req=1, sd_addr, sd_we (VID 0, CPU cpu_we, LDR 1), sd_ds (VID 2'b11, CPU cpu_ds, LDR 2'b11), sd_din (CPU/LDR data, else unchanged). With no winner: grant=IDLE, sd_req=0, and the controller refreshes.
- Acks are exactly one clk_96 cycle long. At most one ack is high per cycle.
- Latency: request seen at slot edge k → ack at slot edge k+1 (12 cycles). Worst case while idle: 11+12 cycles.
- Request inputs are registered when granted. Changing them after the grant has no effect on the slot in flight.
- If a req drops before its ack, the slot still completes and the ack still pulses.
- Reset mid-slot: the in-flight access is abandoned with no ack. After reset the first grant occurs at the next slot edge.
- clk_8_en high while reset_n low: ignored.

Decomposition:
- Shared package sdram_arb_pkg: grant state encoding (IDLE/VID/CPU/LDR, 2 bits), port index constants, default VID_MAX_RUN.
- One sub-module: sdram_arb_pick. It is combinational priority/round-robin selection taking eligible reqs, vid_run and rr, and returning the winner. It is unit-testable in isolation.

Test Plan:
- cpu_req read addr 0x000123 with sd_dout=0xBEEF presented: granted at slot edge k with sd_req=1 and sd_we=0 → cpu_ack at k+1 (12 cycles later), cpu_dout=0xBEEF.
- cpu_req and vid_req held continuously, VID_MAX_RUN=3: grants VID,VID,VID,CPU,VID,VID,VID,CPU; the CPU port is excluded on its ack edge, so it is never granted twice in a row.
- cpu_req and ldr_req continuous, no video: grants alternate CPU, LDR, CPU, LDR. Loader writes drive sd_we=1 and sd_ds=2'b11.
- CPU write ds=2'b01, din=0x00A5: sd_ds=2'b01, sd_din=0x00A5; cpu_dout stays unchanged after the ack.
- No requests for 3 slots: sd_req=0 throughout and no acks. A req rising one cycle after a slot edge is granted 11 cycles later.
- reset_n low 5 cycles into a video slot: no vid_ack, all outputs return to reset values immediately. After release a pending vid_req is granted at the next clk_8_en.
